onetotwo_demux_stream: RTL and testbench
========================================

Name: onetotwo_demux_stream

Overview:
- Registered 1:2 demultiplexer. The receive-side counterpart of the 2:1 multiplexer: routes a single valid/ready input stream onto output lane A or lane B.
- Lane is chosen by select input S, or by automatic alternation for de-interleaving a stream built by the mux.
- Each lane has a one-entry holding register, so one stalled lane never corrupts the other.
- Sits between the mux-based combiner path and two independent downstream consumers.

Parameters:
- WIDTH, 8, data bits per word.
- CNT_W, 8, width of the per-lane accepted-word counters.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  input word.
- in_valid  input  1  input word present.
- in_ready  output  1  block accepts the word this cycle.
- S  input  1  lane select when alt_en=0 (0=A, 1=B); sampled only on the transfer cycle.
- alt_en  input  1  1 = automatic A/B alternation; S ignored.
- A_data  output  WIDTH  lane A word.
- A_valid  output  1  lane A holds a word.
- A_ready  input  1  lane A consumer accepts.
- B_data  output  WIDTH  lane B word.
- B_valid  output  1  lane B holds a word.
- B_ready  input  1  lane B consumer accepts.
- next_lane  output  1  lane the next accepted word will go to.
- cnt_a  output  CNT_W  words accepted into lane A.
- cnt_b  output  CNT_W  words accepted into lane B.

Behaviour:
- **Reset:** On rising clk with rst=1, the following clear to 0: A_valid, B_valid, A_data, B_data, toggle, cnt_a, cnt_b. Buffered words are discarded. rst has priority over every other event, including mid-transfer.
- **Destination:**
  - dest = alt_en ? toggle : S.
  - next_lane = dest (combinational).
- **Input handshake:**
  - in_ready = ~X_valid | X_ready, where X = dest lane.
  - in_ready is combinational from S, alt_en, toggle, lane state and lane ready. It does not depend on in_valid.
  - Transfer occurs when in_valid & in_ready.
- **On transfer:**
  - dest lane register loads in_data.
  - dest lane valid is set to 1.
  - dest lane counter increments, wrapping modulo 2^CNT_W.
  - Latency: word accepted at edge N is visible on X_data/X_valid after edge N.
- **Lane drain:** X_valid clears when X_ready=1 and that lane is not loaded in the same cycle.
- **Simultaneous drain and load on the same lane:** the new word replaces the old one and X_valid stays 1. This gives full throughput of one word per cycle per lane.
- **Lane independence:** a non-dest lane drains regardless of input activity. A full non-dest lane never blocks the input.
- **Full lane:** X_valid=1 and X_ready=0 on the dest lane gives in_ready=0. X_data holds stable until consumed.
- **Toggle:**
  - While alt_en=0, toggle is held at 0.
  - While alt_en=1, toggle inverts on each transfer. Output order is A, B, A, B, ...; the first word after alt_en rises goes to A.
  - No transfer means no toggle change.
- **Output stability:** X_data changes only on a load into lane X or on reset.
- **Select changes:** S or alt_en may change while in_valid is stalled. The destination is whatever they select on the transfer cycle.
- **Counter wrap:** cnt = 2^CNT_W-1 followed by a transfer gives 0. No saturation and no flag.

Decomposition:
- Package demux_pkg:
  - LANE_A = 1'b0, LANE_B = 1'b1.
  - Default WIDTH and CNT_W constants.
- Sub-module demux_lane_reg, instantiated twice (one per lane). It holds:
  - the one-entry data/valid register;
  - the load/drain logic;
  - the word counter.
  - It exposes: load, data_in, ready_in, data_out, valid_out, can_accept (~valid | ready), count.
- Top level holds toggle, destination select and in_ready muxing.

Test Plan:
1. **Reset mid-operation:** load lane A with 8'hA5 (A_ready=0), then assert rst for 1 cycle → A_valid=0, A_data=0, cnt_a=0, next_lane=0 after the edge.
2. **Select routing:** alt_en=0, S=0, in_data=8'h11, then S=1, in_data=8'h22, both lanes ready=1 → A_data=8'h11 then B_data=8'h22, each valid one cycle after acceptance; cnt_a=1, cnt_b=1.
3. **Alternation:** alt_en=1, stream 8'h01..8'h06 continuously, both ready=1 → lane A gets 01,03,05 and lane B gets 02,04,06; next_lane toggles each cycle; cnt_a=cnt_b=3.
4. **Backpressure and independence:** A_ready=0, S=0, send 8'h3C, then a second word to A → in_ready=0 and A_data stays 3C. Switch S=1 and send 8'h7E → accepted into B while A remains stalled.
5. **Back-to-back with simultaneous drain/load:** A_ready=1 constant, S=0, one word per cycle 8'h10, 8'h11, 8'h12 → in_ready stays 1, A_valid stays 1 for 3 cycles, A_data steps 10→11→12.
6. **Counter wrap:** CNT_W=2, send 5 words to lane B → cnt_b sequence 1,2,3,0,1; cnt_a stays 0.

Source files
------------

// File: rtl/demux_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
// Shared constants for the 1:2 stream demultiplexer.
//   lane_e        : lane identifier (LANE_A = 0, LANE_B = 1)
//   DEF_WIDTH     : default data word width
//   DEF_CNT_W     : default per-lane accepted-word counter width
// -----------------------------------------------------------------------------
package demux_pkg;

   typedef enum logic {
      LANE_A = 1'b0,
      LANE_B = 1'b1
   } lane_e;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_CNT_W = 8;

endpackage : demux_pkg

// File: rtl/demux_lane_reg.sv
// -----------------------------------------------------------------------------
// demux_lane_reg
// One output lane of the demultiplexer: a single-entry data/valid holding
// register with its own accepted-word counter.
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   load       in   write data_in into the lane this cycle
//   data_in    in   word to load
//   ready_in   in   downstream consumer accepts the held word
//   data_out   out  held word
//   valid_out  out  lane holds a word
//   can_accept out  lane can take a new word this cycle (~valid | ready)
//   count      out  number of words loaded, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module demux_lane_reg
   import demux_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] data_in,
   input  logic             ready_in,
   output logic [WIDTH-1:0] data_out,
   output logic             valid_out,
   output logic             can_accept,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] r_data;
   logic             r_valid;
   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_data  <= '0;
         r_valid <= 1'b0;
         r_count <= '0;
      end else if (load) begin
         // A load wins over a drain: the new word replaces the consumed one,
         // so a lane can sustain one word per cycle.
         r_data  <= data_in;
         r_valid <= 1'b1;
         r_count <= r_count + CNT_W'(1);
      end else if (ready_in) begin
         r_valid <= 1'b0;
      end
   end

   assign data_out   = r_data;
   assign valid_out  = r_valid;
   assign count      = r_count;
   assign can_accept = ~r_valid | ready_in;

endmodule : demux_lane_reg

// File: rtl/onetotwo_demux_stream.sv
// -----------------------------------------------------------------------------
// onetotwo_demux_stream
// Registered 1:2 demultiplexer: routes one valid/ready stream onto lane A or
// lane B, chosen by S or by automatic A/B alternation (alt_en=1).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_data/in_valid/in_ready input stream
//   S                         lane select when alt_en=0 (0=A, 1=B)
//   alt_en                    1 = alternate A, B, A, ... ; S ignored
//   A_data/A_valid/A_ready    lane A output stream
//   B_data/B_valid/B_ready    lane B output stream
//   next_lane                 lane the next accepted word goes to
//   cnt_a, cnt_b              per-lane accepted-word counters (wrapping)
// -----------------------------------------------------------------------------
module onetotwo_demux_stream
   import demux_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             S,
   input  logic             alt_en,
   output logic [WIDTH-1:0] A_data,
   output logic             A_valid,
   input  logic             A_ready,
   output logic [WIDTH-1:0] B_data,
   output logic             B_valid,
   input  logic             B_ready,
   output logic             next_lane,
   output logic [CNT_W-1:0] cnt_a,
   output logic [CNT_W-1:0] cnt_b
);

   logic  r_toggle;
   lane_e w_dest;
   logic  w_xfer;
   logic  w_load_a;
   logic  w_load_b;
   logic  w_can_a;
   logic  w_can_b;

   assign w_dest    = lane_e'(alt_en ? r_toggle : S);
   assign next_lane = w_dest;

   // Only the destination lane gates the input; a full idle lane never blocks.
   assign in_ready  = (w_dest == LANE_B) ? w_can_b : w_can_a;
   assign w_xfer    = in_valid & in_ready;
   assign w_load_a  = w_xfer & (w_dest == LANE_A);
   assign w_load_b  = w_xfer & (w_dest == LANE_B);

   // Toggle parks at 0 while alternation is off so the first word after
   // alt_en rises lands in lane A.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_toggle <= 1'b0;
      end else if (!alt_en) begin
         r_toggle <= 1'b0;
      end else if (w_xfer) begin
         r_toggle <= ~r_toggle;
      end
   end

   demux_lane_reg #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_lane_a (
      .clk        (clk),
      .rst        (rst),
      .load       (w_load_a),
      .data_in    (in_data),
      .ready_in   (A_ready),
      .data_out   (A_data),
      .valid_out  (A_valid),
      .can_accept (w_can_a),
      .count      (cnt_a)
   );

   demux_lane_reg #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_lane_b (
      .clk        (clk),
      .rst        (rst),
      .load       (w_load_b),
      .data_in    (in_data),
      .ready_in   (B_ready),
      .data_out   (B_data),
      .valid_out  (B_valid),
      .can_accept (w_can_b),
      .count      (cnt_b)
   );

endmodule : onetotwo_demux_stream

// File: tb/tb_onetotwo_demux_stream.sv
// -----------------------------------------------------------------------------
// tb_onetotwo_demux_stream
// Directed bench for onetotwo_demux_stream. Main instance uses the default
// 8-bit counters; a second instance with CNT_W=2 exercises counter wrap.
// -----------------------------------------------------------------------------
module tb_onetotwo_demux_stream;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       S;
   logic       alt_en;
   logic [7:0] A_data;
   logic       A_valid;
   logic       A_ready;
   logic [7:0] B_data;
   logic       B_valid;
   logic       B_ready;
   logic       next_lane;
   logic [7:0] cnt_a;
   logic [7:0] cnt_b;

   logic [7:0] u2_in_data;
   logic       u2_in_valid;
   logic       u2_in_ready;
   logic       u2_S;
   logic       u2_alt_en;
   logic [7:0] u2_A_data;
   logic       u2_A_valid;
   logic       u2_A_ready;
   logic [7:0] u2_B_data;
   logic       u2_B_valid;
   logic       u2_B_ready;
   logic       u2_next_lane;
   logic [1:0] u2_cnt_a;
   logic [1:0] u2_cnt_b;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   onetotwo_demux_stream #(.WIDTH(8), .CNT_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .S         (S),
      .alt_en    (alt_en),
      .A_data    (A_data),
      .A_valid   (A_valid),
      .A_ready   (A_ready),
      .B_data    (B_data),
      .B_valid   (B_valid),
      .B_ready   (B_ready),
      .next_lane (next_lane),
      .cnt_a     (cnt_a),
      .cnt_b     (cnt_b)
   );

   onetotwo_demux_stream #(.WIDTH(8), .CNT_W(2)) dut2 (
      .clk       (clk),
      .rst       (rst),
      .in_data   (u2_in_data),
      .in_valid  (u2_in_valid),
      .in_ready  (u2_in_ready),
      .S         (u2_S),
      .alt_en    (u2_alt_en),
      .A_data    (u2_A_data),
      .A_valid   (u2_A_valid),
      .A_ready   (u2_A_ready),
      .B_data    (u2_B_data),
      .B_valid   (u2_B_valid),
      .B_ready   (u2_B_ready),
      .next_lane (u2_next_lane),
      .cnt_a     (u2_cnt_a),
      .cnt_b     (u2_cnt_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
         $display("check %s obs=%0h exp=%0h ok", tag, obs, exp);
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge; inputs are driven and outputs sampled 1 ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_data = '0; in_valid = 1'b0; S = 1'b0; alt_en = 1'b0;
      A_ready = 1'b0; B_ready = 1'b0;
      u2_in_data = '0; u2_in_valid = 1'b0; u2_S = 1'b0; u2_alt_en = 1'b0;
      u2_A_ready = 1'b0; u2_B_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      chk("rst_A_valid", 32'(A_valid), 32'h0);
      chk("rst_B_valid", 32'(B_valid), 32'h0);
      chk("rst_A_data", 32'(A_data), 32'h0);
      chk("rst_cnt_a", 32'(cnt_a), 32'h0);
      chk("rst_cnt_b", 32'(cnt_b), 32'h0);
      chk("rst_next_lane", 32'(next_lane), 32'h0);

      // 1. Reset mid-operation
      in_data = 8'hA5; in_valid = 1'b1; S = 1'b0;
      tick();
      in_valid = 1'b0;
      chk("t1_A_valid_loaded", 32'(A_valid), 32'h1);
      chk("t1_A_data_loaded", 32'(A_data), 32'hA5);
      chk("t1_cnt_a_loaded", 32'(cnt_a), 32'h1);
      do_reset();
      chk("t1_A_valid_rst", 32'(A_valid), 32'h0);
      chk("t1_A_data_rst", 32'(A_data), 32'h0);
      chk("t1_cnt_a_rst", 32'(cnt_a), 32'h0);
      chk("t1_next_lane_rst", 32'(next_lane), 32'h0);

      // 2. Select routing
      A_ready = 1'b1; B_ready = 1'b1; S = 1'b0; in_data = 8'h11; in_valid = 1'b1;
      #1;
      chk("t2_in_ready", 32'(in_ready), 32'h1);
      chk("t2_next_lane_A", 32'(next_lane), 32'h0);
      tick();
      chk("t2_A_valid", 32'(A_valid), 32'h1);
      chk("t2_A_data", 32'(A_data), 32'h11);
      chk("t2_B_valid_idle", 32'(B_valid), 32'h0);
      S = 1'b1; in_data = 8'h22;
      tick();
      in_valid = 1'b0;
      chk("t2_B_valid", 32'(B_valid), 32'h1);
      chk("t2_B_data", 32'(B_data), 32'h22);
      chk("t2_A_drained", 32'(A_valid), 32'h0);
      chk("t2_cnt_a", 32'(cnt_a), 32'h1);
      chk("t2_cnt_b", 32'(cnt_b), 32'h1);
      tick();
      chk("t2_B_drained", 32'(B_valid), 32'h0);
      chk("t2_A_data_stable", 32'(A_data), 32'h11);

      // 3. Alternation
      do_reset();
      alt_en = 1'b1; S = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         in_data = 8'(i); in_valid = 1'b1;
         #1;
         chk($sformatf("t3_next_lane_%0d", i), 32'(next_lane), 32'((i - 1) % 2));
         tick();
         if (i % 2 == 1) begin
            chk($sformatf("t3_A_data_%0d", i), 32'(A_data), 32'(i));
            chk($sformatf("t3_A_valid_%0d", i), 32'(A_valid), 32'h1);
         end else begin
            chk($sformatf("t3_B_data_%0d", i), 32'(B_data), 32'(i));
            chk($sformatf("t3_B_valid_%0d", i), 32'(B_valid), 32'h1);
         end
      end
      in_valid = 1'b0;
      chk("t3_cnt_a", 32'(cnt_a), 32'h3);
      chk("t3_cnt_b", 32'(cnt_b), 32'h3);
      tick();
      chk("t3_next_lane_idle", 32'(next_lane), 32'h0);
      chk("t3_A_data_final", 32'(A_data), 32'h5);
      alt_en = 1'b0; S = 1'b0;

      // 4. Backpressure and lane independence
      do_reset();
      A_ready = 1'b0; B_ready = 1'b1; S = 1'b0;
      in_data = 8'h3C; in_valid = 1'b1;
      tick();
      in_data = 8'h55;
      #1;
      chk("t4_in_ready_full", 32'(in_ready), 32'h0);
      tick();
      chk("t4_A_data_held", 32'(A_data), 32'h3C);
      chk("t4_A_valid_held", 32'(A_valid), 32'h1);
      chk("t4_cnt_a_once", 32'(cnt_a), 32'h1);
      S = 1'b1; in_data = 8'h7E;
      #1;
      chk("t4_in_ready_B", 32'(in_ready), 32'h1);
      tick();
      in_valid = 1'b0;
      chk("t4_B_data", 32'(B_data), 32'h7E);
      chk("t4_B_valid", 32'(B_valid), 32'h1);
      chk("t4_A_data_still", 32'(A_data), 32'h3C);
      chk("t4_A_valid_still", 32'(A_valid), 32'h1);
      chk("t4_cnt_b", 32'(cnt_b), 32'h1);

      // 5. Back-to-back with simultaneous drain/load
      do_reset();
      A_ready = 1'b1; B_ready = 1'b1; S = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_data = 8'h10 + 8'(k); in_valid = 1'b1;
         #1;
         chk($sformatf("t5_in_ready_%0d", k), 32'(in_ready), 32'h1);
         tick();
         chk($sformatf("t5_A_valid_%0d", k), 32'(A_valid), 32'h1);
         chk($sformatf("t5_A_data_%0d", k), 32'(A_data), 32'h10 + 32'(k));
      end
      in_valid = 1'b0;
      tick();
      chk("t5_A_drained", 32'(A_valid), 32'h0);
      chk("t5_cnt_a", 32'(cnt_a), 32'h3);

      // 6. Counter wrap on the CNT_W=2 instance
      u2_S = 1'b1; u2_B_ready = 1'b1; u2_A_ready = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         u2_in_data = 8'(k); u2_in_valid = 1'b1;
         tick();
         chk($sformatf("t6_cnt_b_%0d", k), 32'(u2_cnt_b), 32'(k % 4));
      end
      u2_in_valid = 1'b0;
      chk("t6_cnt_a", 32'(u2_cnt_a), 32'h0);
      chk("t6_B_data", 32'(u2_B_data), 32'h5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_onetotwo_demux_stream
